hdmi_pll_supervisor: RTL and testbench
======================================

// Module: hdmi_pll_supervisor
// PURPOSE
//   Sequences and supervises the HDMI PLL from the free-running init clock.
//   - Pulses the PLL reset and waits for lock.
//   - Qualifies lock stability, then releases the HDMI video pipeline reset.
//   - Watches for loss of lock and re-runs the sequence.
//   - Raises a sticky fault after repeated lock failures.
//   Sits between the board reset and the HDMI PLL wrapper; drives its reset input and reads its lock output.
// PARAMETERS
//   RST_CYCLES     32      init_clk cycles pll_rst is held high per attempt (>=1)
//   LOCK_TIMEOUT   100000  cycles allowed in WAIT_LOCK before the attempt fails (2 ms @ 50 MHz)
//   STABLE_CYCLES  1024    consecutive synced-lock cycles required before RUN
//   LOSS_FILT      4       consecutive synced-unlock cycles in RUN that count as lock loss
//   MAX_RETRIES    7       failed attempts tolerated before FAULT (<=15)
// PORTS
//   init_clk       in   1  free-running init clock; the only clock
//   reset          in   1  asynchronous, active-high reset
//   restart        in   1  synchronous one-cycle request to restart the sequence
//   pll_lock       in   1  PLL lock; asynchronous to init_clk
//   pll_rst        out  1  PLL reset, active high
//   hdmi_rst       out  1  HDMI pipeline reset, active high
//   ready          out  1  PLL locked and qualified (state RUN)
//   fault          out  1  sticky: retries exhausted
//   state          out  3  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
//   retry_cnt      out  4  failed attempts since the last RUN entry or restart
//   lock_loss_cnt  out  8  lock-loss events in RUN; saturates at 255
// BEHAVIOUR
// - Reset values: state=RESET_PLL, pll_rst=1, hdmi_rst=1, ready=0, fault=0. All counters and sync flops are 0.
// - pll_lock passes through a 2-flop synchronizer (lock_s); 2-cycle latency.
// - Outputs are flops loaded from the next-state decode, so they change in the same cycle as state. No combinational input->output paths.
// - Output decode by state:
//   - pll_rst = 1 in RESET_PLL and FAULT.
//   - hdmi_rst = 0 only in RUN.
//   - ready = 1 only in RUN.
//   - fault = 1 only in FAULT.
// - A single shared cycle timer clears on every state entry; width is $clog2 of the largest count.
// - RESET_PLL: stay exactly RST_CYCLES cycles, then go to WAIT_LOCK.
// - WAIT_LOCK:
//   - lock_s=1 -> STABLE.
//   - LOCK_TIMEOUT cycles elapse without lock -> fail.
// - STABLE:
//   - STABLE_CYCLES consecutive lock_s=1 cycles -> RUN; retry_cnt clears to 0.
//   - Any lock_s=0 -> fail.
// - Fail:
//   - retry_cnt==MAX_RETRIES -> FAULT.
//   - Otherwise retry_cnt+1 and go to RESET_PLL.
// - RUN:
//   - lock_s=0 for LOSS_FILT consecutive cycles -> RESET_PLL and lock_loss_cnt+1 (saturating). retry_cnt is not incremented.
//   - Shorter low runs are ignored; the filter count resets on lock_s=1.
// - FAULT: absorbing; pll_rst stays high. Exits only via restart or reset.
// - restart=1 in any state (FAULT included) -> RESET_PLL next cycle; retry_cnt=0; fault=0.
//   - restart has priority over every other transition.
//   - lock_loss_cnt is preserved; only reset clears it.
// - Asserting reset mid-sequence forces the reset values immediately, without a clock edge.
// TESTING (params: RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 LOSS_FILT=3 MAX_RETRIES=2)
// - Normal bring-up: lock rises 10 cycles after pll_rst falls.
//   -> pll_rst high exactly 4 cycles.
//   -> ready=1 and hdmi_rst=0 exactly 2+8 cycles after lock_s path settles; retry_cnt=0.
// - Lock never rises.
//   -> 3 pll_rst pulses of 4 cycles, each separated by 20 low cycles.
//   -> then state=4, fault=1, pll_rst stuck 1, retry_cnt=2.
// - In RUN, pll_lock low for 2 cycles -> no change.
//   In RUN, pll_lock low for 3 cycles -> hdmi_rst=1, ready=0, lock_loss_cnt=1, new 4-cycle pll_rst pulse.
// - Lock drops at cycle 5 of STABLE -> retry_cnt=1, state=RESET_PLL.
// - restart in FAULT -> next cycle state=0, fault=0, retry_cnt=0, lock_loss_cnt unchanged.
//   restart in RUN -> same, ready drops next cycle.
// - Async reset asserted mid-RUN between clock edges -> outputs take reset values at once; lock_loss_cnt=0.

Source files
------------

// File: rtl/hdmi_pll_supervisor.sv
// -----------------------------------------------------------------------------
// hdmi_pll_supervisor
//   Sequences and supervises the HDMI PLL from the free-running init clock.
//   Pulses the PLL reset, waits for lock, qualifies lock stability, then
//   releases the HDMI pipeline reset. Loss of lock in RUN re-runs the
//   sequence. Repeated lock failures park the block in a sticky FAULT.
//
// Ports
//   init_clk       in   free-running init clock (only clock)
//   reset          in   asynchronous active-high reset
//   restart        in   one-cycle request to restart the sequence
//   pll_lock       in   PLL lock, asynchronous to init_clk
//   pll_rst        out  PLL reset, active high
//   hdmi_rst       out  HDMI pipeline reset, active high
//   ready          out  PLL locked and qualified (RUN)
//   fault          out  sticky: retries exhausted
//   state          out  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
//   retry_cnt      out  failed attempts since last RUN entry or restart
//   lock_loss_cnt  out  lock-loss events in RUN, saturating at 255
//
// Handshakes: there are none; restart is a single-cycle level sampled on
// the rising edge of init_clk and takes effect on that edge.
// -----------------------------------------------------------------------------
module hdmi_pll_supervisor #(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILT     = 4,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       init_clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       hdmi_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // Shared timer is sized for the largest count used by any state.
    localparam int MAX_A     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B     = (STABLE_CYCLES > LOSS_FILT) ? STABLE_CYCLES : LOSS_FILT;
    localparam int MAX_COUNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW        = $clog2(MAX_COUNT + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] LOSS_LAST    = TW'(LOSS_FILT - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [3:0]    retry_nxt;
    logic [7:0]    loss_nxt;
    logic          attempt_failed;
    logic          sync1;
    logic          lock_s;

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    always_comb begin
        nxt            = cur;
        timer_nxt      = timer + 1'b1;
        retry_nxt      = retry_cnt;
        loss_nxt       = lock_loss_cnt;
        attempt_failed = 1'b0;

        case (cur)
            S_RESET_PLL: begin
                if (timer == RST_LAST) nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) nxt = S_STABLE;
                else if (timer == TIMEOUT_LAST) attempt_failed = 1'b1;
            end
            S_STABLE: begin
                if (!lock_s) begin
                    attempt_failed = 1'b1;
                end else if (timer == STABLE_LAST) begin
                    nxt       = S_RUN;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                // In RUN the timer doubles as the consecutive-unlock filter.
                if (lock_s) begin
                    timer_nxt = '0;
                end else if (timer == LOSS_LAST) begin
                    nxt = S_RESET_PLL;
                    if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
                end
            end
            S_FAULT: begin
                timer_nxt = timer;
            end
            default: begin
                nxt = S_RESET_PLL;
            end
        endcase

        if (attempt_failed) begin
            if (retry_cnt == RETRY_LIMIT) begin
                nxt = S_FAULT;
            end else begin
                retry_nxt = retry_cnt + 4'd1;
                nxt       = S_RESET_PLL;
            end
        end

        // restart overrides every other transition.
        if (restart) begin
            nxt       = S_RESET_PLL;
            retry_nxt = '0;
        end

        // Timer clears on every state entry (a restart re-enters RESET_PLL).
        if (restart || (nxt != cur)) timer_nxt = '0;
    end

    // State, counters and outputs all load from the next-state decode, so the
    // outputs move in the same cycle as state with no input->output path.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            cur           <= S_RESET_PLL;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            hdmi_rst      <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cur           <= nxt;
            timer         <= timer_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (nxt == S_RESET_PLL) || (nxt == S_FAULT);
            hdmi_rst      <= (nxt != S_RUN);
            ready         <= (nxt == S_RUN);
            fault         <= (nxt == S_FAULT);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// -----------------------------------------------------------------------------
// tb_hdmi_pll_supervisor
//   Scoreboard bench: the driver predicts every clock edge with a behavioural
//   model and queues the expected output vector; a monitor pops and compares
//   one vector after each rising edge. Directed checks cover the sequencing
//   timings, FAULT, restart and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_hdmi_pll_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int LOSS_FILT     = 3;
    localparam int MAX_RETRIES   = 2;
    localparam int W             = 19;

    // ---------------- clock / reset ----------------
    logic       init_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       restart  = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       hdmi_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    always #5 init_clk = ~init_clk;

    hdmi_pll_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOSS_FILT    (LOSS_FILT),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .init_clk     (init_clk),
        .reset        (reset),
        .restart      (restart),
        .pll_lock     (pll_lock),
        .pll_rst      (pll_rst),
        .hdmi_rst     (hdmi_rst),
        .ready        (ready),
        .fault        (fault),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // Phase numbers follow the state output encoding. m_elapsed is the number
    // of cycles already spent in the current phase; m_low_run is the length
    // of the current unlock run in RUN. Lock seen by the sequencer is the
    // pll_lock value sampled two edges earlier.
    int   m_state;
    int   m_elapsed;
    int   m_low_run;
    int   m_retry;
    int   m_loss;
    logic hist[$];

    task automatic model_reset();
        m_state   = 0;
        m_elapsed = 0;
        m_low_run = 0;
        m_retry   = 0;
        m_loss    = 0;
        hist.delete();
    endtask

    task automatic enter(input int s);
        m_state   = s;
        m_elapsed = 0;
        m_low_run = 0;
    endtask

    task automatic attempt_fail();
        if (m_retry == MAX_RETRIES) begin
            enter(4);
        end else begin
            m_retry = m_retry + 1;
            enter(0);
        end
    endtask

    task automatic model_edge(input logic lk, input logic rs);
        logic ls;
        ls = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        hist.push_back(lk);
        if (hist.size() > 4) void'(hist.pop_front());
        if (rs) begin
            enter(0);
            m_retry = 0;
        end else begin
            case (m_state)
                0: begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed == RST_CYCLES) enter(1);
                end
                1: begin
                    if (ls) begin
                        enter(2);
                    end else begin
                        m_elapsed = m_elapsed + 1;
                        if (m_elapsed == LOCK_TIMEOUT) attempt_fail();
                    end
                end
                2: begin
                    if (!ls) begin
                        attempt_fail();
                    end else begin
                        m_elapsed = m_elapsed + 1;
                        if (m_elapsed == STABLE_CYCLES) begin
                            enter(3);
                            m_retry = 0;
                        end
                    end
                end
                3: begin
                    if (ls) begin
                        m_low_run = 0;
                    end else begin
                        m_low_run = m_low_run + 1;
                        if (m_low_run == LOSS_FILT) begin
                            enter(0);
                            if (m_loss < 255) m_loss = m_loss + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        logic e_pll_rst, e_hdmi_rst, e_ready, e_fault;
        e_pll_rst  = (m_state == 0) || (m_state == 4);
        e_hdmi_rst = (m_state != 3);
        e_ready    = (m_state == 3);
        e_fault    = (m_state == 4);
        return {e_pll_rst, e_hdmi_rst, e_ready, e_fault, 3'(m_state), 4'(m_retry), 8'(m_loss)};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {pll_rst, hdmi_rst, ready, fault, state, retry_cnt, lock_loss_cnt};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        forever begin
            @(posedge init_clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v  = exp_q.pop_front();
                got_v  = dut_vec();
                checks = checks + 1;
                if (got_v !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL edge_vec t=%0t got rst/hrst/rdy/flt=%b st=%0d retry=%0d loss=%0d required rst/hrst/rdy/flt=%b st=%0d retry=%0d loss=%0d",
                             $time, got_v[18:15], got_v[14:12], got_v[11:8], got_v[7:0],
                             exp_v[18:15], exp_v[14:12], exp_v[11:8], exp_v[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int req);
        checks = checks + 1;
        if (got != req) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, req);
        end
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge.
    task automatic step(input logic lk, input logic rs);
        pll_lock = lk;
        restart  = rs;
        model_edge(lk, rs);
        exp_q.push_back(model_vec());
        @(negedge init_clk);
        restart = 1'b0;
    endtask

    task automatic run_until(input string name, input int target, input logic lk, input int limit);
        int n;
        n = 0;
        while (m_state != target && n < limit) begin
            step(lk, 1'b0);
            n = n + 1;
        end
        check(name, int'(state), target);
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic async_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        check({name, "_pll_rst"}, int'(pll_rst), 1);
        check({name, "_hdmi_rst"}, int'(hdmi_rst), 1);
        check({name, "_ready"}, int'(ready), 0);
        check({name, "_fault"}, int'(fault), 0);
        check({name, "_state"}, int'(state), 0);
        check({name, "_retry"}, int'(retry_cnt), 0);
        check({name, "_loss"}, int'(lock_loss_cnt), 0);
        repeat (2) @(negedge init_clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors = errors + 1;
        $display("FAIL watchdog t=%0t got=timeout required=finish", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_hi;
        int n_lo;
        int first_ready;
        int low_left;
        logic lk;
        logic rs;

        model_reset();
        repeat (2) @(negedge init_clk);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_hdmi_rst", int'(hdmi_rst), 1);
        check("reset_ready", int'(ready), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_state", int'(state), 0);
        reset = 1'b0;

        // Normal bring-up: lock rises 10 cycles after pll_rst falls.
        n_hi        = 0;
        first_ready = -1;
        for (int i = 0; i < 40; i++) begin
            if (pll_rst) n_hi = n_hi + 1;
            if (ready && first_ready < 0) first_ready = i;
            step(i >= RST_CYCLES + 10, 1'b0);
        end
        check("bringup_pll_rst_len", n_hi, RST_CYCLES);
        // lock sampled at edge 15, +2 sync, +8 stable -> RUN after edge 25
        check("bringup_ready_time", first_ready, RST_CYCLES + 10 + 1 + 2 + STABLE_CYCLES);
        check("bringup_ready", int'(ready), 1);
        check("bringup_hdmi_rst", int'(hdmi_rst), 0);
        check("bringup_retry", int'(retry_cnt), 0);

        // Short unlock glitch in RUN is filtered.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        check("glitch2_ready", int'(ready), 1);
        check("glitch2_loss", int'(lock_loss_cnt), 0);

        // Three-cycle unlock counts as lock loss and re-sequences.
        repeat (3) step(1'b0, 1'b0);
        n_hi = 0;
        n_lo = 0;
        for (int i = 0; i < 30; i++) begin
            if (pll_rst) n_hi = n_hi + 1;
            if (!ready) n_lo = n_lo + 1;
            step(1'b1, 1'b0);
        end
        check("loss_pll_rst_len", n_hi, RST_CYCLES);
        check("loss_count", int'(lock_loss_cnt), 1);
        check("loss_relock_ready", int'(ready), 1);
        check("loss_saw_not_ready", int'(n_lo > 0), 1);

        // Lock drops early in STABLE -> one failed attempt.
        step(1'b1, 1'b1);
        run_until("stable_reach", 2, 1'b1, 50);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run_until("stable_drop_state", 0, 1'b0, 20);
        check("stable_drop_retry", int'(retry_cnt), 1);

        // Lock never rises: three attempts, then FAULT.
        step(1'b0, 1'b1);
        n_hi = 0;
        n_lo = 0;
        for (int i = 0; i < 200 && m_state != 4; i++) begin
            if (pll_rst && !fault) n_hi = n_hi + 1;
            if (!pll_rst) n_lo = n_lo + 1;
            step(1'b0, 1'b0);
        end
        check("nolock_rst_cycles", n_hi, (MAX_RETRIES + 1) * RST_CYCLES);
        check("nolock_low_cycles", n_lo, (MAX_RETRIES + 1) * LOCK_TIMEOUT);
        repeat (10) step(1'b1, 1'b0);
        check("fault_state", int'(state), 4);
        check("fault_flag", int'(fault), 1);
        check("fault_pll_rst", int'(pll_rst), 1);
        check("fault_retry", int'(retry_cnt), MAX_RETRIES);

        // restart in FAULT and in RUN.
        step(1'b1, 1'b1);
        check("restart_fault_state", int'(state), 0);
        check("restart_fault_flag", int'(fault), 0);
        check("restart_fault_retry", int'(retry_cnt), 0);
        check("restart_fault_loss", int'(lock_loss_cnt), 1);
        run_until("restart_to_run", 3, 1'b1, 60);
        step(1'b1, 1'b1);
        check("restart_run_ready", int'(ready), 0);
        check("restart_run_state", int'(state), 0);
        check("restart_run_loss", int'(lock_loss_cnt), 1);

        // Randomized lock behaviour with occasional restarts.
        low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (low_left > 0) begin
                lk       = 1'b0;
                low_left = low_left - 1;
            end else if ($urandom_range(0, 99) < 6) begin
                lk       = 1'b0;
                low_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                      : int'($urandom_range(1, 5));
            end else begin
                lk = 1'b1;
            end
            rs = ($urandom_range(0, 199) == 0);
            step(lk, rs);
        end

        // Asynchronous reset mid-RUN.
        step(1'b1, 1'b1);
        run_until("pre_reset_run", 3, 1'b1, 60);
        async_reset("async_run");
        repeat (20) step(1'b1, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
